branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side dynamic branch predictor for the RV32I pipeline. It sits at the opposite end of the branch-resolution path from the execute-stage branch unit: it predicts taken/not-taken and the target for a fetch PC, then consumes the resolved outcome to train its table. When the resolved outcome differs from the prediction, it raises a registered redirect. Storage is a direct-mapped table of valid, tag, target and 2-bit saturating counter per entry.

## Interface
- INDEX_BITS, 4, log2 of table entries; index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
- clk_in  input  1  single clock, all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- lookup_valid_in  input  1  fetch PC valid this cycle
- lookup_pc_in  input  32  fetch PC, word aligned
- predict_taken_out  output  1  combinational prediction; 0 when lookup_valid_in=0
- predict_target_out  output  32  combinational predicted next PC
- update_valid_in  input  1  resolved branch presented this cycle
- update_pc_in  input  32  PC of resolved branch
- update_taken_in  input  1  actual outcome, driven from the branch unit's taken output
- update_target_in  input  32  actual branch target
- update_pred_taken_in  input  1  prediction made for this branch at fetch
- update_pred_target_in  input  32  next PC predicted at fetch
- mispredict_out  output  1  one-cycle registered redirect pulse
- redirect_pc_out  output  32  registered correct next PC, valid while mispredict_out=1
- mispredict_count_out  output  32  registered count of mispredictions

## Operation
- Entry state: valid, tag (32-INDEX_BITS-2 bits), target[31:0], ctr[1:0].
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup:
  - hit = valid & tag match.
  - predict_taken_out = lookup_valid_in & hit & ctr[1].
  - predict_target_out = predict_taken_out ? entry target : lookup_pc_in + 4, mod 2^32.
- Update, on update_valid_in & !rst_in:
  - Hit with taken: ctr increments, saturating at 11; target is overwritten with update_target_in.
  - Hit with not-taken: ctr decrements, saturating at 00; target is unchanged.
  - Miss with taken: the entry is allocated or overwritten. valid=1, tag and target are written, ctr=10.
  - Miss with not-taken: no table change.
- Misprediction check, evaluated on each update:
  - Condition: (update_pred_taken_in != update_taken_in) | (update_taken_in & update_pred_taken_in & update_pred_target_in != update_target_in).
  - The correct PC is update_taken_in ? update_target_in : update_pc_in + 4.
- Counter arithmetic: mispredict_count_out wraps at 2^32. Not-taken updates never modify target.

## Timing
- Lookup has zero latency and is purely combinational from the table registers.
- Table writes become visible to lookups the cycle after the update edge.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update contents.
- Misprediction path:
  - mispredict_out, redirect_pc_out and the count increment all register on the edge that samples the update.
  - Latency is 1 cycle, and the pulse lasts exactly 1 cycle unless the next update also mispredicts.
  - Back-to-back updates are accepted every cycle; there is no backpressure.
- Reset values: all valid=0, all ctr=01, targets=0, mispredict_out=0, redirect_pc_out=0, mispredict_count_out=0.
- Reset mid-operation: an update coincident with rst_in is dropped. It causes no table write and no count increment, and the table is cleared.
- Reset asserted for any number of cycles has the same effect.
- Aliasing: PCs with equal index and different tag evict each other. There is no replacement policy beyond overwrite.

## Test plan
- Reset, then lookup pc=0x100: predict_taken_out=0 and predict_target_out=0x104.
- Update pc=0x100, taken=1, target=0x80, pred_taken=0:
  - Next cycle: mispredict_out=1, redirect_pc_out=0x80, count=1.
  - Then lookup 0x100 returns taken=1, target=0x80.
- From ctr=10 at 0x100, apply two not-taken updates with pred_taken=1:
  - Two mispredict pulses, redirects 0x104 and 0x104, count +2.
  - ctr=00; lookup 0x100 returns taken=0, target=0x104.
- Saturation: three taken updates at 0x100 bring ctr to 11. One not-taken update brings it to 10, and the lookup still predicts taken to 0x80.
- Aliasing and target check:
  - Taken update at 0x140 (same index, different tag) with target 0x200 replaces the entry, so lookup 0x100 now misses and returns 0x104.
  - An update with pred_taken=1, taken=1 and pred_target 0x80 while actual is 0x200 raises mispredict_out with redirect 0x200.
- Reset mid-operation: rst_in=1 in the same cycle as a mispredicting update.
  - No pulse and count stays 0.
  - Prior entries are invalid afterwards, and lookup 0x100 returns taken=0, target=0x104.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and branch-resolution signals of the branch predictor.
// Signal suffixes (_in/_out) are named from the predictor's point of view.
interface branch_predictor_if;
  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic        predict_taken_out;
  logic [31:0] predict_target_out;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;
  logic        update_pred_taken_in;
  logic [31:0] update_pred_target_in;
  logic        mispredict_out;
  logic [31:0] redirect_pc_out;
  logic [31:0] mispredict_count_out;

  modport master (
    output lookup_valid_in, lookup_pc_in,
    output update_valid_in, update_pc_in, update_taken_in, update_target_in,
    output update_pred_taken_in, update_pred_target_in,
    input  predict_taken_out, predict_target_out,
    input  mispredict_out, redirect_pc_out, mispredict_count_out
  );

  modport slave (
    input  lookup_valid_in, lookup_pc_in,
    input  update_valid_in, update_pc_in, update_taken_in, update_target_in,
    input  update_pred_taken_in, update_pred_target_in,
    output predict_taken_out, predict_target_out,
    output mispredict_out, redirect_pc_out, mispredict_count_out
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational lookup, trained by resolved
// branches, with a registered redirect pulse and misprediction counter.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  branch_predictor_if.slave bp
);
  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned TagW    = 32 - INDEX_BITS - 2;

  logic [Entries-1:0] r_valid;
  logic [TagW-1:0]    r_tag    [Entries];
  logic [31:0]        r_target [Entries];
  logic [1:0]         r_ctr    [Entries];
  logic               r_mispredict;
  logic [31:0]        r_redirect;
  logic [31:0]        r_count;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TagW-1:0]       w_lk_tag;
  logic                  w_lk_taken;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TagW-1:0]       w_up_tag;
  logic                  w_up_hit;
  logic [1:0]            w_ctr_next;
  logic                  w_mispredict;
  logic [31:0]           w_redirect;

  assign w_lk_idx   = bp.lookup_pc_in[INDEX_BITS+1:2];
  assign w_lk_tag   = bp.lookup_pc_in[31:INDEX_BITS+2];
  assign w_lk_taken = bp.lookup_valid_in & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag)
                      & r_ctr[w_lk_idx][1];

  assign bp.predict_taken_out  = w_lk_taken;
  assign bp.predict_target_out = w_lk_taken ? r_target[w_lk_idx] : bp.lookup_pc_in + 32'd4;

  assign w_up_idx = bp.update_pc_in[INDEX_BITS+1:2];
  assign w_up_tag = bp.update_pc_in[31:INDEX_BITS+2];
  assign w_up_hit = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);

  always_comb begin
    w_ctr_next = r_ctr[w_up_idx];
    if (bp.update_taken_in && r_ctr[w_up_idx] != 2'b11) begin
      w_ctr_next = r_ctr[w_up_idx] + 2'b01;
    end else if (!bp.update_taken_in && r_ctr[w_up_idx] != 2'b00) begin
      w_ctr_next = r_ctr[w_up_idx] - 2'b01;
    end
  end

  // A taken/taken pair still mispredicts when the fetch-time target was wrong.
  assign w_mispredict = bp.update_valid_in &
                        ((bp.update_pred_taken_in != bp.update_taken_in) |
                         (bp.update_taken_in & bp.update_pred_taken_in &
                          (bp.update_pred_target_in != bp.update_target_in)));
  assign w_redirect   = bp.update_taken_in ? bp.update_target_in : bp.update_pc_in + 32'd4;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid      <= '0;
      for (int i = 0; i < Entries; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
      r_count      <= '0;
    end else begin
      r_mispredict <= w_mispredict;
      if (w_mispredict) begin
        r_redirect <= w_redirect;
        r_count    <= r_count + 32'd1;
      end
      if (bp.update_valid_in) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_ctr_next;
          if (bp.update_taken_in) r_target[w_up_idx] <= bp.update_target_in;
        end else if (bp.update_taken_in) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= bp.update_target_in;
          r_ctr[w_up_idx]    <= 2'b10;
        end
      end
    end
  end

  assign bp.mispredict_out       = r_mispredict;
  assign bp.redirect_pc_out      = r_redirect;
  assign bp.mispredict_count_out = r_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios followed by random traffic,
// checked against a table model built from the predictor's behavioural rules.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if u_bp_if ();

  branch_predictor #(.INDEX_BITS(4)) u_dut (
    .clk_in(clk),
    .rst_in(rst),
    .bp    (u_bp_if)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } lk_t;

  typedef struct {
    logic        mis;
    logic [31:0] redirect;
    logic [31:0] count;
  } mp_t;

  lk_t lk_q[$];
  mp_t mp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 16 entries, counter as a plain 0..3 integer
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic [31:0] m_count;
  logic [31:0] m_redirect;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit model_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit model_taken(logic [31:0] pc);
    return model_hit(pc) && m_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic logic [31:0] model_target(logic [31:0] pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_count    = '0;
    m_redirect = '0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle of stimulus; expectations go to the scoreboard queues.
  task automatic cycle(bit r, bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut,
                       logic [31:0] utgt, bit upt, logic [31:0] uptgt);
    lk_t lk;
    mp_t mp;
    int unsigned i;
    @(negedge clk);
    rst                           = r;
    u_bp_if.lookup_valid_in       = lv;
    u_bp_if.lookup_pc_in          = lpc;
    u_bp_if.update_valid_in       = uv;
    u_bp_if.update_pc_in          = upc;
    u_bp_if.update_taken_in       = ut;
    u_bp_if.update_target_in      = utgt;
    u_bp_if.update_pred_taken_in  = upt;
    u_bp_if.update_pred_target_in = uptgt;

    lk.taken  = lv && model_taken(lpc);
    lk.target = lk.taken ? m_target[idx_of(lpc)] : lpc + 32'd4;
    lk_q.push_back(lk);

    mp.mis = 1'b0;
    if (r) begin
      model_reset();
    end else if (uv) begin
      mp.mis = (upt != ut) || (ut && upt && uptgt != utgt);
      if (mp.mis) begin
        m_count++;
        m_redirect = ut ? utgt : upc + 32'd4;
      end
      i = idx_of(upc);
      if (model_hit(upc)) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
    mp.redirect = m_redirect;
    mp.count    = m_count;
    mp_q.push_back(mp);
  endtask

  task automatic lookup(logic [31:0] pc);
    cycle(1'b0, 1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic update(logic [31:0] pc, bit t, logic [31:0] tgt, bit pt, logic [31:0] ptgt);
    cycle(1'b0, 1'b0, '0, 1'b1, pc, t, tgt, pt, ptgt);
  endtask

  // Monitor: lookup compared before the edge, registered outputs just after it
  initial begin
    lk_t lk;
    mp_t mp;
    forever begin
      @(negedge clk);
      #3;
      if (lk_q.size() > 0) begin
        lk = lk_q.pop_front();
        check("predict_taken", {31'd0, u_bp_if.predict_taken_out}, {31'd0, lk.taken});
        check("predict_target", u_bp_if.predict_target_out, lk.target);
      end
      @(posedge clk);
      #1;
      if (mp_q.size() > 0) begin
        mp = mp_q.pop_front();
        check("mispredict", {31'd0, u_bp_if.mispredict_out}, {31'd0, mp.mis});
        if (mp.mis) check("redirect_pc", u_bp_if.redirect_pc_out, mp.redirect);
        check("mispredict_count", u_bp_if.mispredict_count_out, mp.count);
      end
    end
  end

  initial begin
    logic [31:0] pc, tgt, ptgt;
    bit t, pt;
    u_bp_if.lookup_valid_in       = 1'b0;
    u_bp_if.lookup_pc_in          = '0;
    u_bp_if.update_valid_in       = 1'b0;
    u_bp_if.update_pc_in          = '0;
    u_bp_if.update_taken_in       = 1'b0;
    u_bp_if.update_target_in      = '0;
    u_bp_if.update_pred_taken_in  = 1'b0;
    u_bp_if.update_pred_target_in = '0;
    model_reset();

    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    lookup(32'h100);
    update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    lookup(32'h100);
    update(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    update(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h100);
    for (int k = 0; k < 3; k++) update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    update(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup(32'h100);
    update(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    lookup(32'h100);
    lookup(32'h140);
    update(32'h140, 1'b1, 32'h200, 1'b1, 32'h80);
    lookup(32'h104);
    cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    lookup(32'h100);
    lookup(32'h140);

    for (int k = 0; k < 600; k++) begin
      pc   = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
      t    = 1'($urandom_range(0, 1));
      tgt  = {$urandom_range(0, 7), 2'b00} << 4;
      if ($urandom_range(0, 9) < 7) begin
        pt   = model_taken(pc);
        ptgt = model_target(pc);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = $urandom_range(0, 1) ? tgt : 32'h4 * $urandom_range(0, 255);
      end
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
            32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2),
            1'($urandom_range(0, 3) != 0), pc, t, tgt, pt, ptgt);
    end
    lookup(32'h1000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (lk_q.size() == 0 && mp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0",
                  lk_q.size(), mp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
